bp_me_lce_req_arbiter: RTL and testbench

Round-robin arbiter that shares one LCE-to-CCE request link among `num_req_p` requesting LCEs. It locks the link to one requester for the duration of a multi-beat message (header plus data beats), so messages never interleave. It also enforces a per-requester cap on outstanding requests, with credits returned by the per-LCE request-complete pulse. It sits between the LCE request outputs and the coherence network injection point, in the same ME layer as the LCE tracing/monitoring logic.

---
 rtl/bp_me_lce_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_bp_me_lce_req_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_lce_req_arbiter.sv
// Round-robin arbiter sharing one LCE->CCE request link among num_req_p LCEs,
// locking the link for multi-beat messages and capping outstanding requests per LCE.
module bp_me_lce_req_arbiter #(
  parameter int unsigned num_req_p         = 4,
  parameter int unsigned header_width_p    = 64,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned max_outstanding_p = 2,
  localparam int unsigned lg_req_lp        = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int unsigned cred_width_lp    = $clog2(max_outstanding_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p*header_width_p-1:0] req_header_i,
  input  logic [num_req_p*data_width_p-1:0]   req_data_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p-1:0]                req_last_i,
  output logic [num_req_p-1:0]                req_ready_and_o,
  input  logic [num_req_p-1:0]                complete_i,
  output logic [header_width_p-1:0]           out_header_o,
  output logic [data_width_p-1:0]             out_data_o,
  output logic                                out_v_o,
  output logic                                out_last_o,
  output logic [lg_req_lp-1:0]                out_src_o,
  input  logic                                out_ready_and_i,
  output logic                                busy_o,
  output logic                                err_o
);

  typedef enum logic {e_idle, e_locked} state_e;

  state_e                   state_q, state_d;
  logic [lg_req_lp-1:0]     rr_q, rr_d;
  logic [lg_req_lp-1:0]     grant_q, grant_d;
  logic [cred_width_lp-1:0] cred_q [num_req_p];
  logic [cred_width_lp-1:0] cred_d [num_req_p];
  logic                     err_q, err_d;

  logic [num_req_p-1:0] elig;
  logic [num_req_p-1:0] take;
  logic [lg_req_lp-1:0] win, sel, sel_nxt, idx_l;
  logic                 any_elig, hs;
  int unsigned          idx;

  // Rotating priority search starting at rr_q
  always_comb begin
    for (int unsigned i = 0; i < num_req_p; i++) begin
      elig[i] = req_v_i[i] & (cred_q[i] != '0);
    end
    any_elig = |elig;
    win      = '0;
    idx      = 0;
    idx_l    = '0;
    for (int unsigned k = num_req_p; k > 0; k--) begin
      idx   = (32'(rr_q) + k - 1) % num_req_p;
      idx_l = lg_req_lp'(idx);
      if (elig[idx_l]) begin
        win = idx_l;
      end
    end
  end

  // Reset forces the mux onto slice 0 so outputs are well defined
  assign sel          = !reset_i ? '0 : (state_q == e_locked) ? grant_q : win;
  assign sel_nxt      = (sel == lg_req_lp'(num_req_p - 1)) ? '0 : sel + lg_req_lp'(1);
  assign out_header_o = req_header_i[32'(sel)*header_width_p +: header_width_p];
  assign out_data_o   = req_data_i[32'(sel)*data_width_p +: data_width_p];
  assign out_last_o   = req_last_i[sel];
  assign out_src_o    = sel;
  assign busy_o       = (state_q == e_locked);
  assign err_o        = err_q;
  assign hs           = out_v_o & out_ready_and_i;

  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    grant_d         = grant_q;
    out_v_o         = 1'b0;
    req_ready_and_o = '0;
    take            = '0;
    if (reset_i) begin
      unique case (state_q)
        e_idle: begin
          out_v_o              = any_elig;
          req_ready_and_o[sel] = any_elig & out_ready_and_i;
          if (hs) begin
            take[sel] = 1'b1;
            if (out_last_o) begin
              rr_d = sel_nxt;
            end else begin
              grant_d = sel;
              state_d = e_locked;
            end
          end
        end
        e_locked: begin
          out_v_o              = req_v_i[sel];
          req_ready_and_o[sel] = out_ready_and_i;
          if (hs && out_last_o) begin
            rr_d    = sel_nxt;
            state_d = e_idle;
          end
        end
        default: state_d = e_idle;
      endcase
    end
  end

  // Credits: take on first beat, return on complete; over-return saturates and flags
  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      cred_d[i] = cred_q[i];
      if (take[i] && !complete_i[i]) begin
        cred_d[i] = cred_q[i] - cred_width_lp'(1);
      end else if (!take[i] && complete_i[i]) begin
        if (cred_q[i] == cred_width_lp'(max_outstanding_p)) begin
          err_d = 1'b1;
        end else begin
          cred_d[i] = cred_q[i] + cred_width_lp'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= e_idle;
      rr_q    <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
        cred_q[i] <= cred_width_lp'(max_outstanding_p);
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < num_req_p; i++) begin
        cred_q[i] <= cred_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bp_me_lce_req_arbiter.sv
// Scoreboard bench for bp_me_lce_req_arbiter with default parameters.
module tb_bp_me_lce_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned HW = 64;
  localparam int unsigned DW = 64;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N*HW-1:0] req_header_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_v_i, req_last_i, req_ready_and_o, complete_i;
  logic [HW-1:0]   out_header_o;
  logic [DW-1:0]   out_data_o;
  logic            out_v_o, out_last_o, out_ready_and_i, busy_o, err_o;
  logic [1:0]      out_src_o;

  bp_me_lce_req_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_header_i(req_header_i), .req_data_i(req_data_i),
    .req_v_i(req_v_i), .req_last_i(req_last_i),
    .req_ready_and_o(req_ready_and_o), .complete_i(complete_i),
    .out_header_o(out_header_o), .out_data_o(out_data_o),
    .out_v_o(out_v_o), .out_last_o(out_last_o), .out_src_o(out_src_o),
    .out_ready_and_i(out_ready_and_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  src;
    logic [63:0] hdr;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input int r, input int t);
    return {32'(r), 32'(t)};
  endfunction

  task automatic set_req(input int r, input logic v, input logic l, input logic [63:0] h);
    req_v_i[r]              = v;
    req_last_i[r]           = l;
    req_header_i[r*HW +: HW] = h;
    req_data_i[r*DW +: DW]   = ~h;
  endtask

  task automatic expect_beat(input int r, input logic [63:0] h, input logic l);
    exp_t e;
    e.src  = 2'(r);
    e.hdr  = h;
    e.last = l;
    sb_q.push_back(e);
  endtask

  task automatic clear_inputs();
    req_header_i    = '0;
    req_data_i      = '0;
    req_v_i         = '0;
    req_last_i      = '0;
    complete_i      = '0;
    out_ready_and_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    clear_inputs();
    sb_q.delete();
    #2;
    reset_i = 1'b1;
  endtask

  task automatic chk_creds(input string tag, input int v);
    for (int i = 0; i < N; i++) chk(tag, 64'(dut.cred_q[i]), 64'(v));
  endtask

  // Every accepted beat must match the next scoreboard entry
  always @(negedge clk_i) begin
    if (reset_i && out_v_o && out_ready_and_i) begin
      chk("sb_pending", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_src", 64'(out_src_o), 64'(e.src));
        chk("sb_hdr", out_header_o, e.hdr);
        chk("sb_data", out_data_o, ~e.hdr);
        chk("sb_last", 64'(out_last_o), 64'(e.last));
      end
    end
  end

  initial begin
    reset_i = 1'b0;
    clear_inputs();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, hdr(i, 1));
    out_ready_and_i = 1'b1;
    #3;
    chk("rst_out_v", 64'(out_v_o), 64'(0));
    chk("rst_ready", 64'(req_ready_and_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_src", 64'(out_src_o), 64'(0));
    chk("rst_hdr", out_header_o, hdr(0, 1));

    // Single beat from requester 1
    do_reset();
    tick();
    set_req(1, 1'b1, 1'b1, hdr(1, 5));
    out_ready_and_i = 1'b1;
    expect_beat(1, hdr(1, 5), 1'b1);
    @(negedge clk_i);
    chk("t1_out_v", 64'(out_v_o), 64'(1));
    chk("t1_src", 64'(out_src_o), 64'(1));
    chk("t1_ready", 64'(req_ready_and_o), 64'(4'b0010));
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    chk("t1_cred1", 64'(dut.cred_q[1]), 64'(1));
    chk("t1_rr", 64'(dut.rr_q), 64'(2));
    complete_i[1] = 1'b1;
    tick();
    complete_i = '0;
    chk("t1_cred1_ret", 64'(dut.cred_q[1]), 64'(2));

    // Round-robin over all four, twice
    do_reset();
    tick();
    out_ready_and_i = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, 1'b1, 1'b1, hdr(i, 16 + pass));
        expect_beat(i, hdr(i, 16 + pass), 1'b1);
      end
      for (int k = 0; k < N; k++) begin
        @(negedge clk_i);
        chk("t2_src", 64'(out_src_o), 64'(k));
        tick();
        set_req(k, 1'b0, 1'b0, '0);
      end
      chk_creds("t2_cred_taken", 1);
      chk("t2_rr_wrap", 64'(dut.rr_q), 64'(0));
      complete_i = '1;
      tick();
      complete_i = '0;
      chk_creds("t2_cred_back", 2);
    end
    chk("t2_drain", 64'(sb_q.size()), 64'(0));

    // Lock across a 3-beat message while requester 0 waits
    do_reset();
    tick();
    out_ready_and_i = 1'b1;
    set_req(2, 1'b1, 1'b0, hdr(2, 1));
    expect_beat(2, hdr(2, 1), 1'b0);
    @(negedge clk_i);
    chk("t3_b1_busy", 64'(busy_o), 64'(0));
    tick();
    set_req(2, 1'b1, 1'b0, hdr(2, 2));
    set_req(0, 1'b1, 1'b1, hdr(0, 49));
    expect_beat(2, hdr(2, 2), 1'b0);
    @(negedge clk_i);
    chk("t3_b2_busy", 64'(busy_o), 64'(1));
    chk("t3_b2_src", 64'(out_src_o), 64'(2));
    tick();
    set_req(2, 1'b1, 1'b1, hdr(2, 3));
    out_ready_and_i = 1'b0;
    @(negedge clk_i);
    chk("t3_stall_v", 64'(out_v_o), 64'(1));
    chk("t3_stall_rdy", 64'(req_ready_and_o), 64'(0));
    chk("t3_stall_src", 64'(out_src_o), 64'(2));
    tick();
    out_ready_and_i = 1'b1;
    expect_beat(2, hdr(2, 3), 1'b1);
    @(negedge clk_i);
    chk("t3_b3_busy", 64'(busy_o), 64'(1));
    tick();
    set_req(2, 1'b0, 1'b0, '0);
    expect_beat(0, hdr(0, 49), 1'b1);
    @(negedge clk_i);
    chk("t3_r0_busy", 64'(busy_o), 64'(0));
    chk("t3_r0_src", 64'(out_src_o), 64'(0));
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    chk("t3_cred2", 64'(dut.cred_q[2]), 64'(1));
    chk("t3_drain", 64'(sb_q.size()), 64'(0));

    // Credit exhaustion on requester 0
    do_reset();
    tick();
    out_ready_and_i = 1'b1;
    set_req(0, 1'b1, 1'b1, hdr(0, 65));
    expect_beat(0, hdr(0, 65), 1'b1);
    tick();
    set_req(0, 1'b1, 1'b1, hdr(0, 66));
    expect_beat(0, hdr(0, 66), 1'b1);
    tick();
    set_req(0, 1'b1, 1'b1, hdr(0, 67));
    @(negedge clk_i);
    chk("t4_blk_v", 64'(out_v_o), 64'(0));
    chk("t4_blk_rdy", 64'(req_ready_and_o), 64'(0));
    chk("t4_cred0", 64'(dut.cred_q[0]), 64'(0));
    tick();
    complete_i[0] = 1'b1;
    @(negedge clk_i);
    chk("t4_ret_v", 64'(out_v_o), 64'(0));
    tick();
    complete_i = '0;
    expect_beat(0, hdr(0, 67), 1'b1);
    @(negedge clk_i);
    chk("t4_go_v", 64'(out_v_o), 64'(1));
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    chk("t4_cred0_end", 64'(dut.cred_q[0]), 64'(0));
    chk("t4_drain", 64'(sb_q.size()), 64'(0));

    // Simultaneous take/return, then over-return error
    do_reset();
    tick();
    out_ready_and_i = 1'b1;
    set_req(0, 1'b1, 1'b1, hdr(0, 81));
    complete_i[0] = 1'b1;
    expect_beat(0, hdr(0, 81), 1'b1);
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    complete_i = '0;
    chk("t5_cred0", 64'(dut.cred_q[0]), 64'(2));
    chk("t5_err0", 64'(err_o), 64'(0));
    complete_i[3] = 1'b1;
    tick();
    complete_i = '0;
    chk("t5_err1", 64'(err_o), 64'(1));
    chk("t5_cred3", 64'(dut.cred_q[3]), 64'(2));
    tick();
    chk("t5_err_sticky", 64'(err_o), 64'(1));

    // Asynchronous reset in the middle of a 4-beat message
    do_reset();
    chk("t6_err_clr", 64'(err_o), 64'(0));
    tick();
    out_ready_and_i = 1'b1;
    set_req(1, 1'b1, 1'b0, hdr(1, 97));
    expect_beat(1, hdr(1, 97), 1'b0);
    tick();
    set_req(1, 1'b1, 1'b0, hdr(1, 98));
    out_ready_and_i = 1'b0;
    @(negedge clk_i);
    chk("t6_lock_busy", 64'(busy_o), 64'(1));
    chk("t6_stall_rdy", 64'(req_ready_and_o), 64'(0));
    tick();
    out_ready_and_i = 1'b1;
    #1;
    chk("t6_pre_v", 64'(out_v_o), 64'(1));
    chk("t6_pre_busy", 64'(busy_o), 64'(1));
    #1;
    reset_i = 1'b0;
    #1;
    chk("t6_rst_v", 64'(out_v_o), 64'(0));
    chk("t6_rst_busy", 64'(busy_o), 64'(0));
    chk("t6_rst_rdy", 64'(req_ready_and_o), 64'(0));
    chk("t6_rst_src", 64'(out_src_o), 64'(0));
    set_req(1, 1'b0, 1'b0, '0);
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    chk("t6_busy", 64'(busy_o), 64'(0));
    chk("t6_rr", 64'(dut.rr_q), 64'(0));
    chk_creds("t6_creds", 2);
    chk("t6_drain", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
